vga_timing_gen: RTL and testbench

Raster timing source for the Pong display path. Generates the horizontal/vertical pixel counters, active-video flag, sync pulses and per-line/per-frame strobes that every renderer (net, paddles, ball, score) and the colour mux consume. It divides the system clock down to the pixel rate and publishes a pixel-enable so clk-domain consumers advance exactly once per pixel.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing source: divides clk to the pixel rate and produces pixel counters,
// active-video flag, sync pulses and line/frame strobes, all registered with zero skew.
module vga_timing_gen #(
  parameter int unsigned H_VIDEO     = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VIDEO     = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned POS_W    = 10;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL  = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VIDEO + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VIDEO + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIDEO + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_d;
  logic [POS_W-1:0] x_d;
  logic [POS_W-1:0] y_d;
  logic             video_d;
  logic             hsync_d;
  logic             vsync_d;
  logic             line_d;
  logic             frame_d;

  // Next position and its decoded attributes, so every output lands on the same edge.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    tick_d  = 1'b0;
    x_d     = pixel_x;
    y_d     = pixel_y;
    video_d = 1'b0;
    hsync_d = ~SYNC_ACTIVE;
    vsync_d = ~SYNC_ACTIVE;
    line_d  = 1'b0;
    frame_d = 1'b0;

    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
    end
    tick_d = (div_d == DIV_W'(CLK_DIV - 1));

    if (pixel_tick) begin
      if (pixel_x == POS_W'(H_TOTAL - 1)) begin
        x_d = '0;
        if (pixel_y == POS_W'(V_TOTAL - 1)) begin
          y_d = '0;
        end else begin
          y_d = pixel_y + POS_W'(1);
        end
      end else begin
        x_d = pixel_x + POS_W'(1);
      end
    end

    video_d = (x_d < POS_W'(H_VIDEO)) && (y_d < POS_W'(V_VIDEO));
    if ((x_d >= POS_W'(HS_START)) && (x_d < POS_W'(HS_END))) begin
      hsync_d = SYNC_ACTIVE;
    end
    if ((y_d >= POS_W'(VS_START)) && (y_d < POS_W'(VS_END))) begin
      vsync_d = SYNC_ACTIVE;
    end
    // Strobes fire only on the edge that enters the new position.
    line_d  = pixel_tick && (x_d == '0);
    frame_d = line_d && (y_d == '0);
  end

  // Reset parks on the last blanking pixel so the first tick enters (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      pixel_tick  <= 1'b0;
      pixel_x     <= POS_W'(H_TOTAL - 1);
      pixel_y     <= POS_W'(V_TOTAL - 1);
      video_on    <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      pixel_tick  <= tick_d;
      pixel_x     <= x_d;
      pixel_y     <= y_d;
      video_on    <= video_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      line_start  <= line_d;
      frame_start <= frame_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 timing for line-level checks, plus three reduced-geometry
// builds (CLK_DIV 1/2/3, one with active-high sync) for frame-level checks.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] px [4];
  logic [9:0] py [4];
  logic [3:0] tk, vo, hs, vs, ls, fs;

  int checks = 0;
  int errors = 0;

  // Per-instance geometry: 0 = default VGA, 1..3 = 15x11 raster with CLK_DIV 1,2,3
  int         ht [4] = '{800, 15, 15, 15};
  int         vt [4] = '{525, 11, 11, 11};
  int         dv [4] = '{2, 1, 2, 3};
  logic [3:0] sa     = 4'b1000;

  // Hand-computed expectations over the window from first frame_start to the next
  int e_lsp  [4] = '{1600, 15, 30, 45};
  int e_fsp  [4] = '{0, 165, 330, 495};
  int e_hs   [4] = '{192, 33, 66, 99};
  int e_hsmn [4] = '{656, 10, 10, 10};
  int e_hsmx [4] = '{751, 12, 12, 12};
  int e_vs   [4] = '{0, 30, 60, 90};
  int e_vid  [4] = '{1281, 48, 96, 144};
  int e_vxmx [4] = '{639, 7, 7, 7};
  int e_vymx [4] = '{1, 5, 5, 5};
  int e_ls   [4] = '{2, 11, 11, 11};
  int e_tick [4] = '{800, 165, 165, 165};

  int st_hs [4], st_vs [4], st_vid [4], st_ls [4], st_tick [4];
  int fs_cnt [4], fs_first [4], fs_second [4], ls_cnt [4], ls_first [4], ls_second [4];
  int hs_min [4], hs_max [4], vs_min [4], vs_max [4], vid_xmax [4], vid_ymax [4];
  int bad_step [4], bad_run [4], run_len [4], prev_x [4], prev_y [4];
  bit chg_seen [4];

  always #5 clk = ~clk;

  vga_timing_gen u_std (
    .clk(clk), .rst(rst), .pixel_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .video_on(vo[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1), .SYNC_ACTIVE(1'b0)
  ) u_div1 (
    .clk(clk), .rst(rst), .pixel_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .video_on(vo[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2), .SYNC_ACTIVE(1'b0)
  ) u_div2 (
    .clk(clk), .rst(rst), .pixel_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .video_on(vo[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3), .SYNC_ACTIVE(1'b1)
  ) u_div3 (
    .clk(clk), .rst(rst), .pixel_tick(tk[3]), .pixel_x(px[3]), .pixel_y(py[3]),
    .video_on(vo[3]), .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]), .frame_start(fs[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_x"},      32'(px[0]), 799);
    chk({pfx, "_y"},      32'(py[0]), 524);
    chk({pfx, "_video"},  32'(vo[0]), 0);
    chk({pfx, "_hsync"},  32'(hs[0]), 1);
    chk({pfx, "_vsync"},  32'(vs[0]), 1);
    chk({pfx, "_tick"},   32'(tk[0]), 0);
    chk({pfx, "_line"},   32'(ls[0]), 0);
    chk({pfx, "_frame"},  32'(fs[0]), 0);
    chk({pfx, "_d3_x"},   32'(px[3]), 14);
    chk({pfx, "_d3_y"},   32'(py[3]), 10);
    chk({pfx, "_d3_hs"},  32'(hs[3]), 0);
    chk({pfx, "_d3_vs"},  32'(vs[3]), 0);
  endtask

  // Called at a negedge: release reset and check the first two clocks afterwards.
  task automatic release_seq(input string pfx);
    rst = 1'b1;
    @(negedge clk);
    chk({pfx, "_c1_tick"},    32'(tk[0]), 1);
    chk({pfx, "_c1_x"},       32'(px[0]), 799);
    chk({pfx, "_c1_d1_tick"}, 32'(tk[1]), 1);
    chk({pfx, "_c1_d3_tick"}, 32'(tk[3]), 0);
    @(negedge clk);
    chk({pfx, "_c2_x"},       32'(px[0]), 0);
    chk({pfx, "_c2_y"},       32'(py[0]), 0);
    chk({pfx, "_c2_video"},   32'(vo[0]), 1);
    chk({pfx, "_c2_line"},    32'(ls[0]), 1);
    chk({pfx, "_c2_frame"},   32'(fs[0]), 1);
    chk({pfx, "_c2_tick"},    32'(tk[0]), 0);
    chk({pfx, "_c2_hsync"},   32'(hs[0]), 1);
    chk({pfx, "_c2_d1_x"},    32'(px[1]), 0);
    chk({pfx, "_c2_d1_frame"},32'(fs[1]), 1);
    chk({pfx, "_c2_d3_x"},    32'(px[3]), 14);
    chk({pfx, "_c2_d3_tick"}, 32'(tk[3]), 1);
  endtask

  // Sample all instances for n negedges, accumulating per-frame statistics.
  task automatic run_window(input int n);
    for (int i = 0; i < 4; i++) begin
      st_hs[i] = 0; st_vs[i] = 0; st_vid[i] = 0; st_ls[i] = 0; st_tick[i] = 0;
      fs_cnt[i] = 0; fs_first[i] = -1; fs_second[i] = -1;
      ls_cnt[i] = 0; ls_first[i] = -1; ls_second[i] = -1;
      hs_min[i] = 9999; hs_max[i] = -1; vs_min[i] = 9999; vs_max[i] = -1;
      vid_xmax[i] = -1; vid_ymax[i] = -1; bad_step[i] = 0; bad_run[i] = 0;
      run_len[i] = 0; chg_seen[i] = 1'b0;
      prev_x[i] = int'(px[i]); prev_y[i] = int'(py[i]);
    end
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 4; i++) begin
        int x, y, ex, ey;
        x = int'(px[i]);
        y = int'(py[i]);
        if (fs[i]) begin
          fs_cnt[i]++;
          if (fs_cnt[i] == 1) fs_first[i] = s;
          else if (fs_cnt[i] == 2) fs_second[i] = s;
        end
        if (ls[i]) begin
          ls_cnt[i]++;
          if (ls_cnt[i] == 1) ls_first[i] = s;
          else if (ls_cnt[i] == 2) ls_second[i] = s;
        end
        if (fs_cnt[i] == 1) begin
          if (hs[i] == sa[i]) begin
            st_hs[i]++;
            if (x < hs_min[i]) hs_min[i] = x;
            if (x > hs_max[i]) hs_max[i] = x;
          end
          if (vs[i] == sa[i]) begin
            st_vs[i]++;
            if (y < vs_min[i]) vs_min[i] = y;
            if (y > vs_max[i]) vs_max[i] = y;
          end
          if (vo[i]) begin
            st_vid[i]++;
            if (x > vid_xmax[i]) vid_xmax[i] = x;
            if (y > vid_ymax[i]) vid_ymax[i] = y;
          end
          if (ls[i]) st_ls[i]++;
          if (tk[i]) st_tick[i]++;
        end
        if (x != prev_x[i] || y != prev_y[i]) begin
          ex = (prev_x[i] == ht[i] - 1) ? 0 : prev_x[i] + 1;
          ey = prev_y[i];
          if (prev_x[i] == ht[i] - 1) ey = (prev_y[i] == vt[i] - 1) ? 0 : prev_y[i] + 1;
          if (x != ex || y != ey) bad_step[i]++;
          if (chg_seen[i] && run_len[i] != dv[i]) bad_run[i]++;
          chg_seen[i] = 1'b1;
          run_len[i]  = 1;
          prev_x[i]   = x;
          prev_y[i]   = y;
        end else begin
          run_len[i]++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_window(input string pfx);
    for (int i = 0; i < 4; i++) begin
      string t;
      t = $sformatf("%s_u%0d", pfx, i);
      chk({t, "_line_period"}, ls_second[i] - ls_first[i], e_lsp[i]);
      chk({t, "_hsync_cnt"},   st_hs[i],    e_hs[i]);
      chk({t, "_hsync_xmin"},  hs_min[i],   e_hsmn[i]);
      chk({t, "_hsync_xmax"},  hs_max[i],   e_hsmx[i]);
      chk({t, "_vsync_cnt"},   st_vs[i],    e_vs[i]);
      chk({t, "_video_cnt"},   st_vid[i],   e_vid[i]);
      chk({t, "_video_xmax"},  vid_xmax[i], e_vxmx[i]);
      chk({t, "_video_ymax"},  vid_ymax[i], e_vymx[i]);
      chk({t, "_line_cnt"},    st_ls[i],    e_ls[i]);
      chk({t, "_tick_cnt"},    st_tick[i],  e_tick[i]);
      chk({t, "_bad_step"},    bad_step[i], 0);
      chk({t, "_bad_hold"},    bad_run[i],  0);
      if (i == 0) begin
        chk({t, "_frame_cnt"}, fs_cnt[i], 1);
      end else begin
        chk({t, "_frame_period"}, fs_second[i] - fs_first[i], e_fsp[i]);
        chk({t, "_vsync_ymin"},   vs_min[i], 7);
        chk({t, "_vsync_ymax"},   vs_max[i], 8);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    release_seq("por");
    run_window(1601);
    check_window("win1");

    for (int k = 0; k < 2000 && px[0] != 10'd300; k++) @(negedge clk);
    chk("reach_x300", 32'(px[0]), 300);
    // Assert reset between edges and look before the next posedge.
    #2 rst = 1'b0;
    #1 check_reset("mid");
    repeat (2) @(negedge clk);
    release_seq("mid");
    run_window(1601);
    check_window("win2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
